// File: rtl/lv1_lv2_bus_arbiter_pkg.sv
// Shared types and constants for the L1-L2 bus arbiter.
package lv1_lv2_arb_pkg;

  localparam int NUM_CORES = 4;
  localparam int CORE_WID  = 2;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    SNOOP,
    LV2
  } arb_state_e;

  // Caller guarantees one-hot (or zero) input.
  function automatic logic [CORE_WID-1:0] onehot_to_idx(input logic [NUM_CORES-1:0] oh);
    logic [CORE_WID-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (oh[i]) idx = idx | CORE_WID'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lv1_lv2_bus_arbiter_if.sv
// L1-L2 bus handshake bundle: master side is the arbiter, slave side the requesters.
interface lv1_lv2_bus_if;
  import lv1_lv2_arb_pkg::*;

  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc;
  logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc;
  logic [NUM_CORES-1:0] bus_lv1_lv2_req_snoop;
  logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_snoop;
  logic                 bus_lv1_lv2_req_lv2;
  logic                 bus_lv1_lv2_gnt_lv2;
  logic                 bus_busy;
  logic [CORE_WID-1:0]  gnt_owner;
  logic                 arb_timeout;

  modport master (
    input  bus_lv1_lv2_req_proc, bus_lv1_lv2_req_snoop, bus_lv1_lv2_req_lv2,
    output bus_lv1_lv2_gnt_proc, bus_lv1_lv2_gnt_snoop, bus_lv1_lv2_gnt_lv2,
    output bus_busy, gnt_owner, arb_timeout
  );

  modport slave (
    output bus_lv1_lv2_req_proc, bus_lv1_lv2_req_snoop, bus_lv1_lv2_req_lv2,
    input  bus_lv1_lv2_gnt_proc, bus_lv1_lv2_gnt_snoop, bus_lv1_lv2_gnt_lv2,
    input  bus_busy, gnt_owner, arb_timeout
  );

endinterface

// File: rtl/lv1_lv2_bus_arbiter_rr_picker_4.sv
// Combinational 4-way round-robin picker: first unmasked request at or after ptr wins.
module rr_picker_4 (
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic [3:0] win,
  output logic       any
);

  logic [3:0] eff;
  logic [3:0] rot;
  logic [1:0] pos;
  logic [1:0] win_idx;

  assign eff = req & ~mask;
  assign any = |eff;

  // rot[0] is the request at the pointer, rot[3] the one searched last.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = eff[ptr + 2'(gi)];
    end
  endgenerate

  always_comb begin
    pos = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) pos = 2'(k);
    end
    win_idx = ptr + pos;
    win     = any ? (4'b0001 << win_idx) : 4'b0000;
  end

endmodule

// File: rtl/lv1_lv2_bus_arbiter.sv
// Round-robin arbiter for the shared L1-L2 bus (proc grant, nested snoop / L2 sub-grants).
// Optional watchdog enabled by defining LV1_LV2_ARB_TIMEOUT_EN.
module lv1_lv2_bus_arbiter
  import lv1_lv2_arb_pkg::*;
#(
  parameter int NUM_CORES   = lv1_lv2_arb_pkg::NUM_CORES,
  parameter int CORE_WID    = lv1_lv2_arb_pkg::CORE_WID,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_WID     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  lv1_lv2_bus_if.master     bus
);

  arb_state_e           state_reg, state_next;
  logic [NUM_CORES-1:0] gnt_proc_reg, gnt_proc_next;
  logic [NUM_CORES-1:0] gnt_snoop_reg, gnt_snoop_next;
  logic                 gnt_lv2_reg, gnt_lv2_next;
  logic                 busy_reg, busy_next;
  logic                 timeout_reg, timeout_next;
  logic [CORE_WID-1:0]  owner_reg, owner_next;
  logic [CORE_WID-1:0]  proc_ptr_reg, proc_ptr_next;
  logic [CORE_WID-1:0]  snoop_ptr_reg, snoop_ptr_next;

  logic [NUM_CORES-1:0] proc_win, snoop_win;
  logic                 proc_any, snoop_any;
  logic [CORE_WID-1:0]  proc_idx, snoop_idx;
  logic                 owner_hold, snoop_hold;
  logic                 expire;

  rr_picker_4 u_proc_pick (
    .req  (bus.bus_lv1_lv2_req_proc),
    .mask ('0),
    .ptr  (proc_ptr_reg),
    .win  (proc_win),
    .any  (proc_any)
  );

  // The owner's own snoop request is masked out by its proc grant vector.
  rr_picker_4 u_snoop_pick (
    .req  (bus.bus_lv1_lv2_req_snoop),
    .mask (gnt_proc_reg),
    .ptr  (snoop_ptr_reg),
    .win  (snoop_win),
    .any  (snoop_any)
  );

  assign proc_idx   = onehot_to_idx(proc_win);
  assign snoop_idx  = onehot_to_idx(snoop_win);
  assign owner_hold = bus.bus_lv1_lv2_req_proc[owner_reg];
  assign snoop_hold = |(bus.bus_lv1_lv2_req_snoop & gnt_snoop_reg);

`ifdef LV1_LV2_ARB_TIMEOUT_EN
  logic [CNT_WID-1:0] cnt_reg;

  // Proc grants only issue from IDLE, so clearing in IDLE clears on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = (state_reg != IDLE) && (cnt_reg == CNT_WID'(TIMEOUT_CYC - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    gnt_proc_next  = gnt_proc_reg;
    gnt_snoop_next = gnt_snoop_reg;
    gnt_lv2_next   = gnt_lv2_reg;
    owner_next     = owner_reg;
    proc_ptr_next  = proc_ptr_reg;
    snoop_ptr_next = snoop_ptr_reg;
    timeout_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (proc_any) begin
          state_next    = PROC;
          gnt_proc_next = proc_win;
          owner_next    = proc_idx;
          proc_ptr_next = proc_idx + 1'b1;
        end
      end
      PROC: begin
        if (!owner_hold) begin
          state_next    = IDLE;
          gnt_proc_next = '0;
        end else if (snoop_any) begin
          state_next     = SNOOP;
          gnt_snoop_next = snoop_win;
          snoop_ptr_next = snoop_idx + 1'b1;
        end else if (bus.bus_lv1_lv2_req_lv2) begin
          state_next   = LV2;
          gnt_lv2_next = 1'b1;
        end
      end
      SNOOP: begin
        if (!snoop_hold) begin
          gnt_snoop_next = '0;
          if (owner_hold) begin
            state_next = PROC;
          end else begin
            state_next    = IDLE;
            gnt_proc_next = '0;
          end
        end
      end
      LV2: begin
        if (!bus.bus_lv1_lv2_req_lv2) begin
          gnt_lv2_next = 1'b0;
          if (owner_hold) begin
            state_next = PROC;
          end else begin
            state_next    = IDLE;
            gnt_proc_next = '0;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_proc_next  = '0;
        gnt_snoop_next = '0;
        gnt_lv2_next   = 1'b0;
      end
    endcase

    // Watchdog expiry overrides whatever the request drops would have done.
    if (expire) begin
      state_next     = IDLE;
      gnt_proc_next  = '0;
      gnt_snoop_next = '0;
      gnt_lv2_next   = 1'b0;
      timeout_next   = 1'b1;
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_proc_reg  <= '0;
      gnt_snoop_reg <= '0;
      gnt_lv2_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      owner_reg     <= '0;
      proc_ptr_reg  <= '0;
      snoop_ptr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_proc_reg  <= gnt_proc_next;
      gnt_snoop_reg <= gnt_snoop_next;
      gnt_lv2_reg   <= gnt_lv2_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
      owner_reg     <= owner_next;
      proc_ptr_reg  <= proc_ptr_next;
      snoop_ptr_reg <= snoop_ptr_next;
    end
  end

  assign bus.bus_lv1_lv2_gnt_proc  = gnt_proc_reg;
  assign bus.bus_lv1_lv2_gnt_snoop = gnt_snoop_reg;
  assign bus.bus_lv1_lv2_gnt_lv2   = gnt_lv2_reg;
  assign bus.bus_busy              = busy_reg;
  assign bus.gnt_owner             = owner_reg;
  assign bus.arb_timeout           = timeout_reg;

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// Directed self-checking bench for lv1_lv2_bus_arbiter (watchdog cases follow LV1_LV2_ARB_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_lv1_lv2_bus_arbiter;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   bad_cnt;

  lv1_lv2_bus_if bus ();

  lv1_lv2_bus_arbiter #(
    .TIMEOUT_CYC (16),
    .CNT_WID     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic expect_bus(input string tag, input logic [3:0] gp, input logic [3:0] gs,
                            input logic gl, input logic busy);
    check({tag, ".gnt_proc"},  32'(bus.bus_lv1_lv2_gnt_proc),  32'(gp));
    check({tag, ".gnt_snoop"}, 32'(bus.bus_lv1_lv2_gnt_snoop), 32'(gs));
    check({tag, ".gnt_lv2"},   32'(bus.bus_lv1_lv2_gnt_lv2),   32'(gl));
    check({tag, ".busy"},      32'(bus.bus_busy),              32'(busy));
    $display("t=%0t %s proc=%b snoop=%b lv2=%b busy=%b owner=%0d to=%b", $time, tag,
             bus.bus_lv1_lv2_gnt_proc, bus.bus_lv1_lv2_gnt_snoop, bus.bus_lv1_lv2_gnt_lv2,
             bus.bus_busy, bus.gnt_owner, bus.arb_timeout);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n = 1'b0;
    bus.bus_lv1_lv2_req_proc  = 4'b0000;
    bus.bus_lv1_lv2_req_snoop = 4'b0000;
    bus.bus_lv1_lv2_req_lv2   = 1'b0;
    tick();
    tick();
    expect_bus("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("reset.owner", 32'(bus.gnt_owner), 32'd0);
    check("reset.timeout", 32'(bus.arb_timeout), 32'd0);
    rst_n = 1'b1;
    tick();

    // Round-robin: all four request, each owner releases after 3 granted cycles.
    bus.bus_lv1_lv2_req_proc = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int exp_owner;
      exp_owner = i % 4;
      tick();
      expect_bus("rr.grant", 4'(32'(1) << exp_owner), 4'b0000, 1'b0, 1'b1);
      check("rr.owner", 32'(bus.gnt_owner), 32'(exp_owner));
      tick();
      tick();
      check("rr.hold", 32'(bus.bus_lv1_lv2_gnt_proc), 32'(1) << exp_owner);
      bus.bus_lv1_lv2_req_proc[exp_owner] = 1'b0;
      tick();
      expect_bus("rr.gap", 4'b0000, 4'b0000, 1'b0, 1'b0);
      bus.bus_lv1_lv2_req_proc[exp_owner] = 1'b1;
    end
    bus.bus_lv1_lv2_req_proc = 4'b0000;
    tick();

    // Snoop masking and snoop-over-L2 priority; proc_ptr is 1 here.
    bus.bus_lv1_lv2_req_proc = 4'b0010;
    tick();
    expect_bus("snp.grant", 4'b0010, 4'b0000, 1'b0, 1'b1);
    check("snp.owner", 32'(bus.gnt_owner), 32'd1);
    bus.bus_lv1_lv2_req_snoop = 4'b0110;
    bus.bus_lv1_lv2_req_lv2   = 1'b1;
    tick();
    expect_bus("snp.first", 4'b0010, 4'b0100, 1'b0, 1'b1);
    tick();
    expect_bus("snp.hold", 4'b0010, 4'b0100, 1'b0, 1'b1);
    bus.bus_lv1_lv2_req_snoop = 4'b0010;
    tick();
    expect_bus("snp.gap", 4'b0010, 4'b0000, 1'b0, 1'b1);
    tick();
    expect_bus("snp.lv2", 4'b0010, 4'b0000, 1'b1, 1'b1);
    bus.bus_lv1_lv2_req_lv2 = 1'b0;
    tick();
    expect_bus("snp.lv2done", 4'b0010, 4'b0000, 1'b0, 1'b1);
    bus.bus_lv1_lv2_req_proc  = 4'b0000;
    bus.bus_lv1_lv2_req_snoop = 4'b0000;
    tick();
    expect_bus("snp.release", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Owner 2 drops while L2 holds the bus.
    bus.bus_lv1_lv2_req_proc = 4'b0100;
    tick();
    expect_bus("drop.grant", 4'b0100, 4'b0000, 1'b0, 1'b1);
    bus.bus_lv1_lv2_req_lv2 = 1'b1;
    tick();
    expect_bus("drop.lv2", 4'b0100, 4'b0000, 1'b1, 1'b1);
    bus.bus_lv1_lv2_req_proc = 4'b0000;
    tick();
    expect_bus("drop.keep", 4'b0100, 4'b0000, 1'b1, 1'b1);
    bus.bus_lv1_lv2_req_lv2 = 1'b0;
    tick();
    expect_bus("drop.clear", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset while in LV2.
    bus.bus_lv1_lv2_req_proc = 4'b0001;
    tick();
    expect_bus("arst.grant", 4'b0001, 4'b0000, 1'b0, 1'b1);
    bus.bus_lv1_lv2_req_lv2 = 1'b1;
    tick();
    expect_bus("arst.lv2", 4'b0001, 4'b0000, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_bus("arst.async", 4'b0000, 4'b0000, 1'b0, 1'b0);
    bus.bus_lv1_lv2_req_proc = 4'b1000;
    bus.bus_lv1_lv2_req_lv2  = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    expect_bus("arst.regrant", 4'b1000, 4'b0000, 1'b0, 1'b1);
    check("arst.owner", 32'(bus.gnt_owner), 32'd3);
    bus.bus_lv1_lv2_req_proc = 4'b0000;
    tick();
    expect_bus("arst.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Watchdog: core 0 holds, core 1 pending; proc_ptr is 0 here.
    bus.bus_lv1_lv2_req_proc = 4'b0011;
    tick();
    expect_bus("wd.grant", 4'b0001, 4'b0000, 1'b0, 1'b1);
`ifdef LV1_LV2_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      check("wd.hold", 32'(bus.bus_lv1_lv2_gnt_proc), 32'h1);
      check("wd.nopulse", 32'(bus.arb_timeout), 32'd0);
    end
    tick();
    expect_bus("wd.expire", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("wd.pulse", 32'(bus.arb_timeout), 32'd1);
    tick();
    expect_bus("wd.next", 4'b0010, 4'b0000, 1'b0, 1'b1);
    check("wd.pulse_end", 32'(bus.arb_timeout), 32'd0);
`else
    for (int k = 1; k < 40; k++) begin
      tick();
      check("wd.hold", 32'(bus.bus_lv1_lv2_gnt_proc), 32'h1);
      check("wd.nopulse", 32'(bus.arb_timeout), 32'd0);
    end
    expect_bus("wd.still", 4'b0001, 4'b0000, 1'b0, 1'b1);
`endif
    bus.bus_lv1_lv2_req_proc = 4'b0000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
